dmx_rx: RTL and testbench
=========================

Name: dmx_rx

Overview:
- DMX512 receiver on DMX_IN; replaces the current pin passthrough as a second source of LED channel data.
- Decodes break/MAB/start code/slots and packs slot pairs into 16-bit words.
- Emits a data/address/write_strobe bus with the same shape as the SPI input bus, so the output address decoder consumes it unchanged.
- Sits directly upstream of the per-output address decode and write-strobe generation.

Parameters:
- ADDRESS_BUS_WIDTH, 14: width of the address output.
- CLOCKS_PER_BIT, 96: clk cycles per 4 us DMX bit (24 MHz clk).
- BREAK_MIN_CLOCKS, 2112: consecutive low cycles recognised as a break (88 us).
- BASE_ADDRESS, 0: word address of slots 1/2.
- MAX_SLOTS, 512: data slots accepted per frame; later slots are ignored.

Ports:
- clk  in  1: system clock.
- rst  in  1: synchronous, active-high reset.
- dmx_in  in  1: asynchronous DMX line, idle high.
- data  out  16: packed slot word.
- address  out  ADDRESS_BUS_WIDTH: word address.
- write_strobe  out  1: one-cycle pulse; data/address valid in the same cycle.
- frame_done  out  1: one-cycle pulse at the end of each accepted frame.
- framing_error  out  1: one-cycle pulse when a bad start or stop bit is detected.
- error_count  out  8: saturating error count (see Optional Feature).

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; slot counter and pending byte are cleared.
- Input sampling:
  - dmx_in passes through a 2-FF synchroniser; all logic uses the synchronised value.
- Break detection:
  - A low counter runs in every state and restarts on any high sample.
  - When it reaches BREAK_MIN_CLOCKS:
    - If a valid frame is open, flush it (see Packing).
    - Then enter BREAK.
  - A break interrupts any state, including mid-byte.
- FSM states:
  - IDLE: wait for a break.
  - BREAK: wait for line high, then go to MAB.
  - MAB: on a falling edge go to RX. Slot index is 0.
  - RX: byte receive, 8N2, LSB first. Falling edge is at cycle t.
    - Start bit sampled at t+CLOCKS_PER_BIT/2; high gives framing_error and goes to IDLE.
    - Data bit i sampled at t+CLOCKS_PER_BIT/2+(i+1)*CLOCKS_PER_BIT, for i=0..7.
    - First stop bit sampled at t+CLOCKS_PER_BIT/2+9*CLOCKS_PER_BIT; low gives framing_error and goes to IDLE, which waits for a break.
    - The second stop bit is not checked.
  - SLOT_WAIT: idle-high between slots; a falling edge starts the next byte in RX.
- Start code (slot 0):
  - 0x00 makes the frame valid.
  - Any other value marks the frame ignored: bytes are still framed, but no strobes and no frame_done.
- Packing:
  - Slot 2n+1 goes to data[15:8]; slot 2n+2 goes to data[7:0].
  - write_strobe is asserted the cycle after the stop-bit sample of slot 2n+2, with address = BASE_ADDRESS+n, truncated to ADDRESS_BUS_WIDTH.
  - Odd final slot: when the frame ends, emit {byte, 8'h00} with its word address.
- Frame end:
  - The frame ends on break detection or when slot MAX_SLOTS completes.
  - frame_done pulses in the same cycle as any flush strobe, otherwise alone.
  - After MAX_SLOTS, further bytes are ignored until the next break.
  - A framing error ends the frame with no frame_done; words already strobed stand.
- Timing and reset:
  - write_strobe is never asserted on two consecutive cycles.
  - data/address hold their last values between strobes.
  - rst mid-byte discards the partial byte and pending byte; no strobe is emitted.

Optional Feature:
- Macro: DMX_RX_ERROR_COUNT_EN.
- Defined:
  - error_count increments on each framing_error pulse.
  - It also increments on each ignored start code.
  - It saturates at 255 and is cleared only by rst.
- Undefined: error_count is tied to 0 and no counter logic is built.

Test Plan:
- Break 100 us, MAB 12 us, start 0x00, slots 0x12,0x34,0x56,0x78, then break -> two strobes: {0x1234 @ addr 0} and {0x5678 @ addr 1}; frame_done one cycle with the second break; no framing_error.
- Same frame with a third slot 0xAB -> third strobe {0xAB00 @ addr 2} in the same cycle as frame_done.
- Start code 0xCC with 4 slots -> no write_strobe, no frame_done; error_count=1 when the macro is defined, else 0.
- Slot 3 has its stop bit driven low -> strobe for slots 1/2 only, then framing_error pulse and return to IDLE; subsequent bytes are ignored until the next break.
- BASE_ADDRESS=100, MAX_SLOTS=4, 6 slots sent -> strobes at addr 100 and 101; frame_done after slot 4; slots 5/6 produce nothing.
- rst asserted mid-slot 2 of a valid frame -> all outputs 0 next cycle; no strobe; the next full frame decodes normally.

Source files
------------

// File: rtl/dmx_rx.sv
// dmx_rx: DMX512 line receiver that packs slot pairs into 16-bit words on a data/address/write_strobe bus.
// Latency: a word strobes one cycle after the stop-bit sample of its second slot; odd tails flush at frame end.
// No backpressure: the consumer must take every write_strobe. Optional error counter: DMX_RX_ERROR_COUNT_EN.
module dmx_rx #(
   parameter int ADDRESS_BUS_WIDTH = 14,
   parameter int CLOCKS_PER_BIT    = 96,
   parameter int BREAK_MIN_CLOCKS  = 2112,
   parameter int BASE_ADDRESS      = 0,
   parameter int MAX_SLOTS         = 512
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         dmx_in,
   output logic [15:0]                  data,
   output logic [ADDRESS_BUS_WIDTH-1:0] address,
   output logic                         write_strobe,
   output logic                         frame_done,
   output logic                         framing_error,
   output logic [7:0]                   error_count
);

   localparam int HALF_BIT = CLOCKS_PER_BIT / 2;
   localparam int TW       = $clog2(CLOCKS_PER_BIT + 1);
   localparam int LW       = $clog2(BREAK_MIN_CLOCKS + 1);
   localparam int SW       = $clog2(MAX_SLOTS + 2);
   localparam int WW       = $clog2(MAX_SLOTS / 2 + 2);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_BREAK     = 3'd1,
      S_MAB       = 3'd2,
      S_RX        = 3'd3,
      S_SLOT_WAIT = 3'd4
   } state_t;

   state_t state, state_next;

   // line conditioning
   logic sync_q1, sync_q2, line, line_prev, fall;
   logic [LW-1:0] low_cnt;
   logic break_hit;

   // byte receiver
   logic [TW-1:0] bit_timer;
   logic [3:0]    bit_idx;     // 0 = start, 1..8 = data, 9 = first stop
   logic [7:0]    shift_byte;
   logic          stop_hold;   // stop bit read low on an all-zero byte: break or error, decided later

   logic sample_now, start_bad, stop_sample, byte_done, stop_low_zero, stop_bad, hold_err, frame_err;

   // frame assembly
   logic                         frame_open;
   logic                         pend_vld;
   logic [7:0]                   pend_byte;
   logic                         done_dly;
   logic [SW-1:0]                slot_idx;
   logic [WW-1:0]                word_idx;
   logic [ADDRESS_BUS_WIDTH-1:0] word_addr;

   assign line      = sync_q2;
   assign fall      = line_prev & ~line;
   assign break_hit = ~line && (low_cnt == LW'(BREAK_MIN_CLOCKS - 1));
   assign word_addr = ADDRESS_BUS_WIDTH'(BASE_ADDRESS + int'(word_idx));

   // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle level is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1   <= 1'b1;
         sync_q2   <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         sync_q1   <= dmx_in;
         sync_q2   <= sync_q1;
         line_prev <= sync_q2;
      end
   end

   // Consecutive-low counter; saturates so a long break fires break_hit exactly once.
   always_ff @(posedge clk) begin
      if (rst || line) begin
         low_cnt <= '0;
      end else if (low_cnt != LW'(BREAK_MIN_CLOCKS)) begin
         low_cnt <= low_cnt + LW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; a break overrides every state, including a byte in flight.
   always_comb begin
      state_next = state;
      if (break_hit) begin
         state_next = S_BREAK;
      end else begin
         case (state)
            S_IDLE:      state_next = S_IDLE;
            S_BREAK:     if (line) state_next = S_MAB;
            S_MAB:       if (fall) state_next = S_RX;
            S_RX: begin
               if (frame_err)      state_next = S_IDLE;
               else if (byte_done) state_next = S_SLOT_WAIT;
            end
            S_SLOT_WAIT: if (fall) state_next = S_RX;
            default:     state_next = S_IDLE;
         endcase
      end
   end

   // Output decode: bit-sample strobes and byte/framing outcomes for the current cycle.
   always_comb begin
      sample_now = 1'b0;
      if (state == S_RX && !stop_hold) begin
         if (bit_idx == 4'd0) sample_now = (bit_timer == TW'(HALF_BIT));
         else                 sample_now = (bit_timer == TW'(CLOCKS_PER_BIT));
      end
      start_bad     = sample_now && (bit_idx == 4'd0) && line;
      stop_sample   = sample_now && (bit_idx == 4'd9);
      byte_done     = stop_sample && line;
      stop_low_zero = stop_sample && !line && (shift_byte == 8'h00);
      stop_bad      = stop_sample && !line && (shift_byte != 8'h00);
      // A low stop on an all-zero byte is the leading edge of a break unless the line
      // returns high before the break length is reached.
      hold_err      = (state == S_RX) && stop_hold && line;
      frame_err     = (start_bad || stop_bad || hold_err) && !break_hit;
   end

   // Bit timer and shifter; held at their start values whenever no byte is being received,
   // so the cycle after the detected falling edge is timer value 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_timer  <= TW'(1);
         bit_idx    <= 4'd0;
         shift_byte <= 8'h00;
         stop_hold  <= 1'b0;
      end else if (state != S_RX) begin
         bit_timer  <= TW'(1);
         bit_idx    <= 4'd0;
         stop_hold  <= 1'b0;
      end else if (sample_now) begin
         bit_timer <= TW'(1);
         bit_idx   <= bit_idx + 4'd1;
         if (bit_idx >= 4'd1 && bit_idx <= 4'd8) shift_byte <= {line, shift_byte[7:1]};
         if (stop_low_zero) stop_hold <= 1'b1;
      end else if (!stop_hold) begin
         bit_timer <= bit_timer + TW'(1);
      end
   end

   // Frame assembly: start-code qualification, slot pairing, word strobes, flush and frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         data          <= 16'h0000;
         address       <= '0;
         write_strobe  <= 1'b0;
         frame_done    <= 1'b0;
         framing_error <= 1'b0;
         frame_open    <= 1'b0;
         pend_vld      <= 1'b0;
         pend_byte     <= 8'h00;
         done_dly      <= 1'b0;
         slot_idx      <= '0;
         word_idx      <= '0;
      end else begin
         write_strobe  <= 1'b0;
         frame_done    <= done_dly;
         done_dly      <= 1'b0;
         framing_error <= 1'b0;

         if (break_hit) begin
            // Close an open frame, flushing an unpaired odd slot as the high byte.
            if (frame_open) begin
               frame_done <= 1'b1;
               if (pend_vld) begin
                  data         <= {pend_byte, 8'h00};
                  address      <= word_addr;
                  write_strobe <= 1'b1;
               end
            end
            frame_open <= 1'b0;
            pend_vld   <= 1'b0;
            slot_idx   <= '0;
            word_idx   <= '0;
         end else begin
            if (frame_err) begin
               framing_error <= 1'b1;
               frame_open    <= 1'b0;
               pend_vld      <= 1'b0;
            end

            if (state == S_MAB) begin
               frame_open <= 1'b0;
               pend_vld   <= 1'b0;
               slot_idx   <= '0;
               word_idx   <= '0;
            end

            if (byte_done) begin
               if (slot_idx == '0) begin
                  frame_open <= (shift_byte == 8'h00);
               end else if (frame_open) begin
                  if (slot_idx[0]) begin
                     if (slot_idx == SW'(MAX_SLOTS)) begin
                        // Odd last accepted slot: flush right away together with frame_done.
                        data         <= {shift_byte, 8'h00};
                        address      <= word_addr;
                        write_strobe <= 1'b1;
                        frame_done   <= 1'b1;
                        frame_open   <= 1'b0;
                        pend_vld     <= 1'b0;
                     end else begin
                        pend_byte <= shift_byte;
                        pend_vld  <= 1'b1;
                     end
                  end else begin
                     data         <= {pend_byte, shift_byte};
                     address      <= word_addr;
                     write_strobe <= 1'b1;
                     word_idx     <= word_idx + WW'(1);
                     pend_vld     <= 1'b0;
                     if (slot_idx == SW'(MAX_SLOTS)) begin
                        // Nothing to flush: frame_done follows on its own one cycle later.
                        done_dly   <= 1'b1;
                        frame_open <= 1'b0;
                     end
                  end
               end
               if (slot_idx != SW'(MAX_SLOTS + 1)) slot_idx <= slot_idx + SW'(1);
            end
         end
      end
   end

`ifdef DMX_RX_ERROR_COUNT_EN
   logic err_event;
   assign err_event = frame_err || (byte_done && (slot_idx == '0) && (shift_byte != 8'h00));

   // Saturating count of framing errors and ignored start codes; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         error_count <= 8'h00;
      end else if (err_event && error_count != 8'hFF) begin
         error_count <= error_count + 8'h01;
      end
   end
`else
   assign error_count = 8'h00;
`endif

endmodule

// File: tb/tb_dmx_rx.sv
module tb_dmx_rx;
   localparam int CPB = 16;
   localparam int BMC = 352;
   localparam int AW  = 14;
`ifdef DMX_RX_ERROR_COUNT_EN
   localparam bit EC_EN = 1'b1;
`else
   localparam bit EC_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic dmx = 1'b1;

   logic [15:0]   data_o [2];
   logic [AW-1:0] addr_o [2];
   logic          ws_o   [2];
   logic          fd_o   [2];
   logic          fe_o   [2];
   logic [7:0]    ec_o   [2];

   dmx_rx #(.ADDRESS_BUS_WIDTH(AW), .CLOCKS_PER_BIT(CPB), .BREAK_MIN_CLOCKS(BMC),
            .BASE_ADDRESS(0), .MAX_SLOTS(512)) dut0 (
      .clk(clk), .rst(rst), .dmx_in(dmx), .data(data_o[0]), .address(addr_o[0]),
      .write_strobe(ws_o[0]), .frame_done(fd_o[0]), .framing_error(fe_o[0]), .error_count(ec_o[0]));

   dmx_rx #(.ADDRESS_BUS_WIDTH(AW), .CLOCKS_PER_BIT(CPB), .BREAK_MIN_CLOCKS(BMC),
            .BASE_ADDRESS(100), .MAX_SLOTS(4)) dut1 (
      .clk(clk), .rst(rst), .dmx_in(dmx), .data(data_o[1]), .address(addr_o[1]),
      .write_strobe(ws_o[1]), .frame_done(fd_o[1]), .framing_error(fe_o[1]), .error_count(ec_o[1]));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // current frame description
   logic [7:0] fb [0:15];
   int fn, err_pos, rst_pos, frame_no;

   // observed per frame
   logic [31:0] got [2][0:511];
   int got_n [2], done_n [2], dws_n [2], fe_n [2], consec_n [2];
   logic prev_ws [2];

   // expected per frame
   logic [31:0] exp_w [2][0:511];
   int exp_n [2], exp_done [2], exp_dws [2];
   int exp_fe, ec_model;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge away from the register updates.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (ws_o[i]) begin
            if (got_n[i] < 512) got[i][got_n[i]] = {2'b00, addr_o[i], data_o[i]};
            got_n[i]++;
         end
         if (ws_o[i] && prev_ws[i]) consec_n[i]++;
         prev_ws[i] = ws_o[i];
         if (fd_o[i]) begin
            done_n[i]++;
            if (ws_o[i]) dws_n[i]++;
         end
         if (fe_o[i]) fe_n[i]++;
      end
   end

   task automatic hold(input logic v, input int n);
      dmx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_zero(input string tag);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("%s_data%0d", tag, i), data_o[i], 0);
         check($sformatf("%s_addr%0d", tag, i), addr_o[i], 0);
         check($sformatf("%s_ws%0d", tag, i), ws_o[i], 0);
         check($sformatf("%s_fd%0d", tag, i), fd_o[i], 0);
         check($sformatf("%s_fe%0d", tag, i), fe_o[i], 0);
         check($sformatf("%s_ec%0d", tag, i), ec_o[i], 0);
      end
   endtask

   // One 8N2 slot, LSB first; optional low first stop bit and optional reset pulse mid-byte.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int gap, input bit do_rst);
      hold(1'b0, CPB);
      for (int k = 0; k < 8; k++) begin
         if (do_rst && k == 3) begin
            dmx = b[k];
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_zero("midrst");
            hold(b[k], CPB - 1);
         end else begin
            hold(b[k], CPB);
         end
      end
      hold(~bad_stop, CPB);
      hold(1'b1, CPB + gap);
   endtask

   // Reference: words, frame_done and error effects derived directly from the frame contents.
   task automatic model(input int inst, input int base, input int maxs);
      int nacc, c, used;
      bit ended;
      exp_n[inst] = 0;
      exp_done[inst] = 0;
      exp_dws[inst] = 0;
      if (rst_pos >= 0) return;
      nacc = (err_pos >= 0) ? err_pos : fn;
      if (nacc == 0 || fb[0] != 8'h00) return;
      c = nacc - 1;
      used = (c < maxs) ? c : maxs;
      ended = (c >= maxs) || (err_pos < 0);
      for (int w = 0; w < used / 2; w++) begin
         exp_w[inst][exp_n[inst]] = {2'b00, AW'(base + w), fb[2*w+1], fb[2*w+2]};
         exp_n[inst]++;
      end
      if (ended) begin
         exp_done[inst] = 1;
         if (used % 2 == 1) begin
            exp_w[inst][exp_n[inst]] = {2'b00, AW'(base + used / 2), fb[used], 8'h00};
            exp_n[inst]++;
            exp_dws[inst] = 1;
         end
      end
   endtask

   // MAB, slots, closing break, then compare both instances against the reference.
   task automatic run_frame();
      int nacc, inc;
      for (int i = 0; i < 2; i++) begin
         got_n[i] = 0; done_n[i] = 0; dws_n[i] = 0; fe_n[i] = 0; consec_n[i] = 0;
      end
      hold(1'b1, 3 * CPB);
      for (int j = 0; j < fn; j++)
         send_byte(fb[j], (j == err_pos), $urandom_range(0, 20), (j == rst_pos));
      hold(1'b0, BMC + 60);

      model(0, 0, 512);
      model(1, 100, 4);
      exp_fe = (rst_pos < 0 && err_pos >= 0) ? 1 : 0;
      if (rst_pos >= 0) begin
         ec_model = 0;
      end else begin
         nacc = (err_pos >= 0) ? err_pos : fn;
         inc = ((nacc > 0 && fb[0] != 8'h00) ? 1 : 0) + exp_fe;
         ec_model = (ec_model + inc > 255) ? 255 : ec_model + inc;
      end

      for (int i = 0; i < 2; i++) begin
         check($sformatf("f%0d_i%0d_nwords", frame_no, i), got_n[i], exp_n[i]);
         for (int w = 0; w < exp_n[i] && w < got_n[i]; w++)
            check($sformatf("f%0d_i%0d_word%0d", frame_no, i, w), got[i][w], exp_w[i][w]);
         check($sformatf("f%0d_i%0d_done", frame_no, i), done_n[i], exp_done[i]);
         check($sformatf("f%0d_i%0d_done_with_flush", frame_no, i), dws_n[i], exp_dws[i]);
         check($sformatf("f%0d_i%0d_framing_err", frame_no, i), fe_n[i], exp_fe);
         check($sformatf("f%0d_i%0d_back_to_back", frame_no, i), consec_n[i], 0);
         check($sformatf("f%0d_i%0d_err_count", frame_no, i), ec_o[i], EC_EN ? ec_model : 0);
      end
      frame_no++;
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         got_n[i] = 0; done_n[i] = 0; dws_n[i] = 0; fe_n[i] = 0; consec_n[i] = 0; prev_ws[i] = 1'b0;
      end
      ec_model = 0;
      frame_no = 0;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      hold(1'b1, 20);
      hold(1'b0, BMC + 60);

      // two full words
      fn = 5; err_pos = -1; rst_pos = -1;
      fb[0] = 8'h00; fb[1] = 8'h12; fb[2] = 8'h34; fb[3] = 8'h56; fb[4] = 8'h78;
      run_frame();
      // odd tail flushed with frame_done
      fn = 6; fb[5] = 8'hAB;
      run_frame();
      // ignored start code
      fn = 5; fb[0] = 8'hCC; fb[1] = 8'h01; fb[2] = 8'h02; fb[3] = 8'h03; fb[4] = 8'h04;
      run_frame();
      // bad stop bit on slot 3, later slots ignored
      fn = 6; err_pos = 3;
      fb[0] = 8'h00; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h9C; fb[4] = 8'h44; fb[5] = 8'h55;
      run_frame();
      // six slots: slot limit of the second instance
      fn = 7; err_pos = -1;
      for (int j = 1; j < 7; j++) fb[j] = 8'(8'h10 * j + j);
      run_frame();
      // reset in the middle of slot 2
      fn = 5; rst_pos = 2;
      fb[0] = 8'h00; fb[1] = 8'hA1; fb[2] = 8'hB2; fb[3] = 8'hC3; fb[4] = 8'hD4;
      run_frame();
      rst_pos = -1;

      // randomized frames
      for (int f = 0; f < 8; f++) begin
         fn = $urandom_range(0, 9);
         for (int j = 0; j < 16; j++) fb[j] = 8'($urandom);
         fb[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         err_pos = (fn > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, fn - 1) : -1;
         if (err_pos >= 0) fb[err_pos] = fb[err_pos] | 8'h01;
         run_frame();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
